// File: rtl/wb_commit_if.sv
// MEM -> WB retirement handshake: one instruction per in_valid && in_ready edge.
//   master: MEM stage (drives instruction fields and in_valid, observes in_ready)
//   slave : writeback unit (observes instruction fields, drives in_ready)
interface wb_commit_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [4:0]  in_dest;
  logic [31:0] in_alu_result;
  logic [1:0]  in_load_size;
  logic        in_load_signed;

  modport master (
    output in_valid, in_reg_write, in_mem_to_reg, in_dest,
           in_alu_result, in_load_size, in_load_signed,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_reg_write, in_mem_to_reg, in_dest,
           in_alu_result, in_load_size, in_load_signed,
    output in_ready
  );
endinterface

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: retires MEM-stage instructions, waits for and
// extracts load data, drives the register-file write port and its bypass,
// and counts retirements.
//   clk, reset       : clock, synchronous active-high reset
//   in_if            : retirement handshake (slave side)
//   mem_rdata_valid/mem_rdata : aligned load word from data memory
//   RegWrite/WriteRegister/WriteData : register-file write port (1-cycle pulse)
//   fwd_valid/fwd_reg/fwd_data       : bypass, mirrors the write port
//   misalign_err/timeout_err         : one-cycle error pulses
//   retired_count                    : wrapping retirement counter
module wb_commit_unit #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  wb_commit_if.slave       in_if,
  input  logic             mem_rdata_valid,
  input  logic [31:0]      mem_rdata,
  output logic             RegWrite,
  output logic [4:0]       WriteRegister,
  output logic [31:0]      WriteData,
  output logic             fwd_valid,
  output logic [4:0]       fwd_reg,
  output logic [31:0]      fwd_data,
  output logic             misalign_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] retired_count
);

  localparam int unsigned WAIT_W = 10;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT);

  localparam logic [1:0] S_EMPTY    = 2'd0;
  localparam logic [1:0] S_WAIT_MEM = 2'd1;
  localparam logic [1:0] S_COMMIT   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [4:0]        ld_dest_q, ld_dest_d;
  logic              ld_wr_q, ld_wr_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              ld_signed_q, ld_signed_d;
  logic [1:0]        ld_addr_q, ld_addr_d;
  logic              reg_write_d;
  logic [4:0]        write_reg_d;
  logic [31:0]       write_data_d;
  logic              misalign_d, timeout_d;
  logic [CNT_W-1:0]  retired_d;

  logic              accept;
  logic [1:0]        in_addr_lo;
  logic              in_misaligned;

  // Select the addressed little-endian lane and extend it to 32 bits.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  addr_lo,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{addr_lo, 3'b000} +: 8];
    h = word[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      2'b00:   extract_load = {{24{sgn & b[7]}}, b};
      2'b01:   extract_load = {{16{sgn & h[15]}}, h};
      default: extract_load = word;
    endcase
  endfunction

  assign accept        = in_if.in_valid && ready_q;
  assign in_addr_lo    = in_if.in_alu_result[1:0];
  // Size 11 is treated as a word, hence the test on size[1].
  assign in_misaligned = ((in_if.in_load_size == 2'b01) && in_addr_lo[0]) ||
                         (in_if.in_load_size[1] && (in_addr_lo != 2'b00));

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    ld_dest_d    = ld_dest_q;
    ld_wr_d      = ld_wr_q;
    ld_size_d    = ld_size_q;
    ld_signed_d  = ld_signed_q;
    ld_addr_d    = ld_addr_q;
    reg_write_d  = 1'b0;
    write_reg_d  = WriteRegister;
    write_data_d = WriteData;
    misalign_d   = 1'b0;
    timeout_d    = 1'b0;
    retired_d    = retired_count;

    case (state_q)
      S_WAIT_MEM: begin
        if (mem_rdata_valid) begin
          state_d      = S_COMMIT;
          write_reg_d  = ld_dest_q;
          write_data_d = extract_load(mem_rdata, ld_size_q, ld_addr_q, ld_signed_q);
          reg_write_d  = ld_wr_q && (ld_dest_q != 5'd0);
        end else if (wait_cnt_q + WAIT_W'(1) == WAIT_LAST) begin
          state_d    = S_EMPTY;
          timeout_d  = 1'b1;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      default: begin
        // COMMIT is a single cycle; leaving it retires the instruction.
        if (state_q == S_COMMIT) begin
          retired_d = retired_count + CNT_W'(1);
        end
        state_d = S_EMPTY;
        if (accept) begin
          write_reg_d = in_if.in_dest;
          if (!in_if.in_mem_to_reg) begin
            state_d      = S_COMMIT;
            write_data_d = in_if.in_alu_result;
            reg_write_d  = in_if.in_reg_write && (in_if.in_dest != 5'd0);
          end else if (in_misaligned) begin
            state_d    = S_COMMIT;
            misalign_d = 1'b1;
          end else begin
            state_d     = S_WAIT_MEM;
            wait_cnt_d  = '0;
            ld_dest_d   = in_if.in_dest;
            ld_wr_d     = in_if.in_reg_write;
            ld_size_d   = in_if.in_load_size;
            ld_signed_d = in_if.in_load_signed;
            ld_addr_d   = in_addr_lo;
          end
        end
      end
    endcase

    ready_d = (state_d != S_WAIT_MEM);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_EMPTY;
      ready_q       <= 1'b1;
      wait_cnt_q    <= '0;
      ld_dest_q     <= '0;
      ld_wr_q       <= 1'b0;
      ld_size_q     <= '0;
      ld_signed_q   <= 1'b0;
      ld_addr_q     <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      misalign_err  <= 1'b0;
      timeout_err   <= 1'b0;
      retired_count <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      wait_cnt_q    <= wait_cnt_d;
      ld_dest_q     <= ld_dest_d;
      ld_wr_q       <= ld_wr_d;
      ld_size_q     <= ld_size_d;
      ld_signed_q   <= ld_signed_d;
      ld_addr_q     <= ld_addr_d;
      RegWrite      <= reg_write_d;
      WriteRegister <= write_reg_d;
      WriteData     <= write_data_d;
      misalign_err  <= misalign_d;
      timeout_err   <= timeout_d;
      retired_count <= retired_d;
    end
  end

  assign in_if.in_ready = ready_q;
  assign fwd_valid      = RegWrite;
  assign fwd_reg        = WriteRegister;
  assign fwd_data       = WriteData;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: directed vector table, hand-written corner
// sequences, then random traffic scored against a transaction-level model.
module tb_wb_commit_unit;

  localparam int unsigned MEM_T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic        misalign_err;
  logic        timeout_err;
  logic [31:0] retired_count;

  wb_commit_if bus();

  wb_commit_unit #(.MEM_TIMEOUT(MEM_T), .CNT_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_if           (bus.slave),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .RegWrite        (RegWrite),
    .WriteRegister   (WriteRegister),
    .WriteData       (WriteData),
    .fwd_valid       (fwd_valid),
    .fwd_reg         (fwd_reg),
    .fwd_data        (fwd_data),
    .misalign_err    (misalign_err),
    .timeout_err     (timeout_err),
    .retired_count   (retired_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_ret = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ld;
    logic        rw;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] rd;
    int          dly;
    logic        erw;
    logic [31:0] edata;
    logic        emis;
    logic        eto;
  } vec_t;

  function automatic vec_t mk(input logic ld, input logic rw, input logic [4:0] dst,
                              input logic [31:0] alu, input logic [1:0] sz, input logic sg,
                              input logic [31:0] rd, input int dly, input logic erw,
                              input logic [31:0] edata, input logic emis, input logic eto);
    vec_t v;
    v.ld = ld; v.rw = rw; v.dst = dst; v.alu = alu; v.sz = sz; v.sg = sg;
    v.rd = rd; v.dly = dly; v.erw = erw; v.edata = edata; v.emis = emis; v.eto = eto;
    return v;
  endfunction

  task automatic drive_instr(input logic ld, input logic rw, input logic [4:0] dst,
                             input logic [31:0] alu, input logic [1:0] sz, input logic sg);
    bus.in_mem_to_reg  = ld;
    bus.in_reg_write   = rw;
    bus.in_dest        = dst;
    bus.in_alu_result  = alu;
    bus.in_load_size   = sz;
    bus.in_load_signed = sg;
    bus.in_valid       = 1'b1;
  endtask

  // One instruction, cycle-exact checks from acceptance through retirement.
  task automatic run_vec(input vec_t v, input int idx);
    int n_idle;
    drive_instr(v.ld, v.rw, v.dst, v.alu, v.sz, v.sg);
    tick();
    bus.in_valid = 1'b0;
    if (v.ld && !v.emis) begin
      n_idle = v.eto ? int'(MEM_T) : v.dly;
      for (int i = 0; i < n_idle; i++) begin
        chk($sformatf("v%0d_wait_ready", idx), 32'(bus.in_ready), 32'd0);
        tick();
      end
      if (!v.eto) begin
        mem_rdata_valid = 1'b1;
        mem_rdata       = v.rd;
        tick();
        mem_rdata_valid = 1'b0;
      end
    end
    chk($sformatf("v%0d_regwrite", idx), 32'(RegWrite), 32'(v.erw));
    chk($sformatf("v%0d_fwd_valid", idx), 32'(fwd_valid), 32'(v.erw));
    if (v.erw) begin
      chk($sformatf("v%0d_wreg", idx), 32'(WriteRegister), 32'(v.dst));
      chk($sformatf("v%0d_wdata", idx), WriteData, v.edata);
      chk($sformatf("v%0d_fwd_reg", idx), 32'(fwd_reg), 32'(v.dst));
      chk($sformatf("v%0d_fwd_data", idx), fwd_data, v.edata);
    end
    chk($sformatf("v%0d_misalign", idx), 32'(misalign_err), 32'(v.emis));
    chk($sformatf("v%0d_timeout", idx), 32'(timeout_err), 32'(v.eto));
    chk($sformatf("v%0d_ready", idx), 32'(bus.in_ready), 32'd1);
    // A late data beat after a timeout must be ignored.
    mem_rdata_valid = v.eto;
    mem_rdata       = 32'h5A5A_5A5A;
    tick();
    mem_rdata_valid = 1'b0;
    if (!v.eto) exp_ret++;
    chk($sformatf("v%0d_count", idx), retired_count, exp_ret);
    chk($sformatf("v%0d_pulse_end", idx), 32'({RegWrite, misalign_err, timeout_err}), 32'd0);
  endtask

  // Reference load extraction from plain shift/mask arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] sz,
                                           input logic [1:0] a, input logic sg);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * int'(a))) & 32'hFF;
      if (sg && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * (int'(a) / 2))) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  logic mon_en = 1'b0;
  int   mis_seen = 0, to_seen = 0, exp_mis = 0, exp_to = 0;

  // Scoreboard: every write-port pulse must match the next expected write.
  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (RegWrite) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_write", 32'(WriteRegister), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("rnd_wreg", 32'(WriteRegister), 32'(e.r));
          chk("rnd_wdata", WriteData, e.d);
          chk("rnd_fwd_data", fwd_data, e.d);
        end
      end
      if (misalign_err) mis_seen++;
      if (timeout_err) to_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[16];

  initial begin
    tbl[0]  = mk(0, 1, 5'd5, 32'h1234_5678, 2'd0, 0, 0, 0, 1, 32'h1234_5678, 0, 0);
    tbl[1]  = mk(0, 1, 5'd0, 32'hDEAD_BEEF, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 5'd7, 32'h0000_0042, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 5'd3, 32'h0000_1003, 2'd0, 1, 32'h80FF_0000, 4, 1, 32'hFFFF_FF80, 0, 0);
    tbl[4]  = mk(1, 1, 5'd4, 32'h0000_1002, 2'd1, 0, 32'hBEEF_0000, 0, 1, 32'h0000_BEEF, 0, 0);
    tbl[5]  = mk(1, 1, 5'd6, 32'h0000_1001, 2'd1, 0, 0, 0, 0, 0, 1, 0);
    tbl[6]  = mk(1, 1, 5'd6, 32'h0000_1002, 2'd2, 0, 0, 0, 0, 0, 1, 0);
    tbl[7]  = mk(1, 1, 5'd8, 32'h0000_1000, 2'd2, 0, 32'hCAFE_F00D, 1, 1, 32'hCAFE_F00D, 0, 0);
    tbl[8]  = mk(1, 1, 5'd9, 32'h0000_1001, 2'd0, 0, 32'h0000_A500, 2, 1, 32'h0000_00A5, 0, 0);
    tbl[9]  = mk(1, 1, 5'd10, 32'h0000_1000, 2'd1, 1, 32'h0000_8001, 0, 1, 32'hFFFF_8001, 0, 0);
    tbl[10] = mk(1, 1, 5'd11, 32'h0000_1000, 2'd3, 1, 32'h1122_3344, 3, 1, 32'h1122_3344, 0, 0);
    tbl[11] = mk(1, 1, 5'd0, 32'h0000_1000, 2'd2, 0, 32'h7777_7777, 1, 0, 0, 0, 0);
    tbl[12] = mk(1, 1, 5'd12, 32'h0000_1000, 2'd2, 0, 0, MEM_T, 0, 0, 0, 1);
    tbl[13] = mk(1, 1, 5'd13, 32'h0000_1000, 2'd2, 0, 32'h0BAD_CAFE, MEM_T - 1, 1, 32'h0BAD_CAFE, 0, 0);
    tbl[14] = mk(1, 1, 5'd14, 32'h0000_1000, 2'd0, 1, 32'h0000_007F, 0, 1, 32'h0000_007F, 0, 0);
    tbl[15] = mk(1, 1, 5'd15, 32'h0000_1003, 2'd3, 0, 0, 0, 0, 0, 1, 0);

    reset = 1'b1;
    mem_rdata_valid = 1'b0;
    mem_rdata = '0;
    bus.in_valid = 1'b0;
    drive_instr(0, 0, 5'd0, 32'd0, 2'd0, 0);
    bus.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_wreg", 32'(WriteRegister), 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_errs", 32'({misalign_err, timeout_err}), 32'd0);
    chk("rst_count", retired_count, 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 16; i++) run_vec(tbl[i], i);

    // Back-to-back ALU ops to r1, r2, r3.
    drive_instr(0, 1, 5'd1, 32'h0000_0011, 2'd0, 0);
    tick();
    chk("b2b_ready1", 32'(bus.in_ready), 32'd1);
    drive_instr(0, 1, 5'd2, 32'h0000_0022, 2'd0, 0);
    chk("b2b_rw1", 32'({RegWrite, WriteRegister}), 32'({1'b1, 5'd1}));
    tick();
    chk("b2b_ready2", 32'(bus.in_ready), 32'd1);
    drive_instr(0, 1, 5'd3, 32'h0000_0033, 2'd0, 0);
    chk("b2b_rw2", 32'({RegWrite, WriteRegister}), 32'({1'b1, 5'd2}));
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_rw3", 32'({RegWrite, WriteRegister}), 32'({1'b1, 5'd3}));
    chk("b2b_data3", WriteData, 32'h0000_0033);
    tick();
    exp_ret = exp_ret + 32'd3;
    chk("b2b_idle", 32'(RegWrite), 32'd0);
    chk("b2b_count", retired_count, exp_ret);

    // Reset in the middle of a load wait.
    drive_instr(1, 1, 5'd9, 32'h0000_2000, 2'd2, 0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("rmid_waiting", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_ret = 0;
    chk("rmid_regwrite", 32'(RegWrite), 32'd0);
    chk("rmid_wreg", 32'(WriteRegister), 32'd0);
    chk("rmid_wdata", WriteData, 32'd0);
    chk("rmid_count", retired_count, 32'd0);
    chk("rmid_ready", 32'(bus.in_ready), 32'd1);
    mem_rdata_valid = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rdata_valid = 1'b0;
    chk("rmid_late_data", 32'(RegWrite), 32'd0);
    tick();
    chk("rmid_count2", retired_count, 32'd0);

    // Random traffic against the transaction-level model.
    mon_en = 1'b1;
    for (int t = 0; t < 300; t++) begin
      logic        ld, rw, sg, mis;
      logic [4:0]  dst;
      logic [1:0]  sz, a;
      logic [31:0] alu, rd;
      int          dly, k, gap;
      ld  = ($urandom % 2) == 1;
      rw  = ($urandom % 4) != 0;
      sg  = ($urandom % 2) == 1;
      dst = 5'($urandom % 8);
      sz  = 2'($urandom % 4);
      a   = 2'($urandom % 4);
      alu = ld ? {28'($urandom), 2'b00} | 32'(a) : 32'($urandom);
      rd  = 32'($urandom);
      dly = int'($urandom_range(0, MEM_T + 1));
      mis = ld && ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a != 2'd0));

      if (!ld) begin
        if (rw && dst != 0) exp_q.push_back('{r: dst, d: alu});
        exp_ret++;
      end else if (mis) begin
        exp_mis++;
        exp_ret++;
      end else if (dly >= int'(MEM_T)) begin
        exp_to++;
      end else begin
        if (rw && dst != 0) exp_q.push_back('{r: dst, d: ref_load(rd, sz, a, sg)});
        exp_ret++;
      end

      drive_instr(ld, rw, dst, alu, sz, sg);
      mem_rdata_valid = ($urandom % 4) == 0;
      mem_rdata = 32'($urandom);
      k = 0;
      while (!bus.in_ready && k < 64) begin
        tick();
        k++;
      end
      chk("rnd_ready_wait", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      mem_rdata_valid = 1'b0;
      if (ld && !mis) begin
        repeat (dly) tick();
        mem_rdata_valid = 1'b1;
        mem_rdata = rd;
        tick();
        mem_rdata_valid = 1'b0;
      end
      gap = int'($urandom % 3);
      for (int g = 0; g < gap; g++) begin
        mem_rdata_valid = ($urandom % 3) == 0;
        mem_rdata = 32'($urandom);
        tick();
        mem_rdata_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    repeat (4) tick();
    mon_en = 1'b0;
    chk("rnd_writes_left", 32'(exp_q.size()), 32'd0);
    chk("rnd_misalign_pulses", 32'(mis_seen), 32'(exp_mis));
    chk("rnd_timeout_pulses", 32'(to_seen), 32'(exp_to));
    chk("rnd_count", retired_count, exp_ret);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
